dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// ============================================================================
//  Module   : dmem_responder
//  Brief    : Single-outstanding data-memory responder. Accepts one read or
//             write request at a time, waits WAIT_CYCLES cycles, then returns
//             a one-cycle hit pulse with registered read data / error flag.
//  Option   : DMEM_ERR_CHECK_EN - strobe legality, alignment and range checks
//             (when undefined, only simultaneous read+write is an error and
//             the word index wraps modulo DEPTH_WORDS).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_parameters;
  localparam int xlen = 32;
endpackage

module dmem_responder
  import cpu_parameters::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            r_v,
  input  logic            w_v,
  input  logic [xlen-1:0] req_adr,
  input  logic [xlen-1:0] req_data,
  input  logic [3:0]      req_strobe,
  output logic            ready,
  output logic            hit,
  output logic [15:0]     mem_res,
  output logic            mem_res_error
);

  localparam int         c_idx_w    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] c_cnt_load = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;

  // Latched request
  logic [xlen-1:0]   r_adr;
  logic [xlen-1:0]   r_data;
  logic [3:0]        r_strobe;
  logic              r_is_wr;
  logic              r_both;

  // Storage: deliberately not reset so contents survive rst_n
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_accept;
  logic              w_enter_resp;
  logic              w_idle;
  logic [xlen-1:0]   w_e_adr;
  logic [xlen-1:0]   w_e_data;
  logic [3:0]        w_e_strb;
  logic              w_e_wr;
  logic              w_e_both;
  logic [xlen-1:0]   w_off;
  logic [xlen-1:0]   w_word;
  logic [c_idx_w-1:0] w_idx;
  logic              w_err;
  logic              w_mem_we;
  logic [31:0]       w_rd_word;
  logic [31:0]       w_masked;
  logic [31:0]       w_shifted;
  logic [15:0]       w_res_nxt;

`ifdef DMEM_ERR_CHECK_EN
  function automatic logic f_strobe_legal(input logic [3:0] s);
    case (s)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b0110, 4'b1100, 4'b1111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction
`endif

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle & (r_v | w_v);

  // With zero wait cycles RESP is entered straight from IDLE, so the request
  // fields must come from the ports rather than from the latches.
  assign w_e_adr  = w_idle ? req_adr    : r_adr;
  assign w_e_data = w_idle ? req_data   : r_data;
  assign w_e_strb = w_idle ? req_strobe : r_strobe;
  assign w_e_wr   = w_idle ? w_v        : r_is_wr;
  assign w_e_both = w_idle ? (r_v & w_v) : r_both;

  assign w_off  = w_e_adr - BASE_ADR;
  assign w_word = w_off >> 2;

`ifdef DMEM_ERR_CHECK_EN
  assign w_idx = c_idx_w'(w_word);
  assign w_err = w_e_both
               | ~f_strobe_legal(w_e_strb)
               | ((w_e_strb == 4'b1111) && (w_e_adr[1:0] != 2'b00))
               | (w_word >= xlen'(DEPTH_WORDS));
`else
  assign w_idx = c_idx_w'(w_word % xlen'(DEPTH_WORDS));
  assign w_err = w_e_both;
`endif

  assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0))
                      | ((r_state == S_WAIT) && (r_cnt == 4'd0));
  assign w_mem_we     = w_enter_resp & w_e_wr & ~w_err & rst_n;
  assign w_rd_word    = r_mem[w_idx];

  // Select enabled byte lanes and right-justify from the lowest enabled lane
  always_comb begin
    w_masked  = 32'd0;
    w_shifted = 32'd0;
    for (int b = 0; b < 4; b++) begin
      if (w_e_strb[b]) w_masked[8*b +: 8] = w_rd_word[8*b +: 8];
    end
    if      (w_e_strb[0]) w_shifted = w_masked;
    else if (w_e_strb[1]) w_shifted = w_masked >> 8;
    else if (w_e_strb[2]) w_shifted = w_masked >> 16;
    else                  w_shifted = w_masked >> 24;
    w_res_nxt = (w_err || w_e_wr) ? 16'd0 : w_shifted[15:0];
  end

  // FSM next state, wait counter and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    ready       = 1'b0;
    hit         = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (w_accept) begin
          w_cnt_nxt   = c_cnt_load;
          w_state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = S_RESP;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_RESP: begin
        hit         = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the request on accept; response registers update entering RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adr         <= '0;
      r_data        <= '0;
      r_strobe      <= 4'd0;
      r_is_wr       <= 1'b0;
      r_both        <= 1'b0;
      mem_res       <= 16'd0;
      mem_res_error <= 1'b0;
    end else begin
      if (w_accept) begin
        r_adr    <= req_adr;
        r_data   <= req_data;
        r_strobe <= req_strobe;
        r_is_wr  <= w_v;
        r_both   <= r_v & w_v;
      end
      if (w_enter_resp) begin
        mem_res       <= w_res_nxt;
        mem_res_error <= w_err;
      end
    end
  end

  // Byte-lane write; read above sees the old word (read-before-write)
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_e_strb[b]) r_mem[w_idx][8*b +: 8] <= w_e_data[8*b +: 8];
      end
    end
  end

endmodule

`default_nettype wire
